des_ctrl: RTL and testbench
===========================

DES_CTRL -- requirements
Module: des_ctrl

Interface
REQ-001 SHALL have no parameters; the round count is fixed at 16 and the round index width at 4.
REQ-002 SHALL have the following ports, one per line as name, direction, width, meaning:
- clk_in  input  1  single clock; all state updates on its rising edge.
- rst_n_in  input  1  reset; asynchronous, active-low.
- in_valid_in  input  1  upstream has a 64-bit block ready.
- in_ready_out  output  1  controller can accept a block.
- mode_in  input  1  0 = encrypt, 1 = decrypt; sampled at accept.
- abort_in  input  1  synchronous cancel of the block in flight.
- ip_load_out  output  1  drives des_ip data_in_valid; pulse on accept.
- round_en_out  output  1  round datapath enable.
- round_idx_out  output  4  current round, 0..15.
- key_shift_out  output  2  key-schedule rotate amount for this round (0, 1 or 2).
- key_dir_out  output  1  0 = rotate left (encrypt), 1 = rotate right (decrypt).
- fp_load_out  output  1  final-permutation capture pulse.
- out_valid_out  output  1  result block valid.
- out_ready_in  input  1  downstream accepts the result.
- busy_out  output  1  high in every state except IDLE.

Function
REQ-003 SHALL implement the FSM states IDLE, ROUND, FP and OUT.
REQ-004 IDLE SHALL drive in_ready_out=1; all other states SHALL drive it 0.
REQ-005 Accept SHALL occur when in_valid_in and in_ready_out are both high; ip_load_out SHALL equal that product combinationally, so it is a single-cycle pulse.
REQ-006 On accept, the FSM SHALL move IDLE->ROUND, clear round_idx to 0, and latch mode_in into key_dir_out.
REQ-007 In ROUND, round_en_out SHALL be 1 and round_idx SHALL increment once per cycle.
REQ-008 When round_idx=15 in ROUND, the FSM SHALL move to FP; round_idx SHALL hold 15 and SHALL NOT wrap to 0 until the next accept.
REQ-009 FP SHALL last exactly 1 cycle with fp_load_out=1, then move to OUT.
REQ-010 OUT SHALL hold out_valid_out=1 until out_ready_in=1; the handshake cycle SHALL return the FSM to IDLE.
REQ-011 OUT SHALL NOT change state without out_ready_in, however long the stall.
REQ-012 Latency SHALL be fixed, with accept in cycle T:
- round_en_out high in cycles T+1..T+16;
- fp_load_out high in cycle T+17;
- out_valid_out first high in cycle T+18.
REQ-013 Throughput SHALL be one block per 19 cycles minimum; a new accept SHALL be possible in the cycle after the out handshake.
REQ-014 key_shift_out SHALL be 0 whenever round_en_out=0.
REQ-015 In encrypt mode, key_shift_out SHALL be 1 for rounds 0, 1, 8 and 15, and 2 for all other rounds.
REQ-016 In decrypt mode, key_shift_out SHALL be 0 for round 0, 1 for rounds 1, 8 and 15, and 2 for all other rounds.
REQ-017 The sum of key_shift_out SHALL be 28 over an encrypt block and 27 over a decrypt block.
REQ-018 A change on mode_in after accept SHALL have no effect on the block in flight.
REQ-019 abort_in=1 in ROUND, FP or OUT SHALL return the FSM to IDLE at the next edge.
REQ-020 After an abort, out_valid_out SHALL be 0, no fp_load_out pulse SHALL occur, and round_idx SHALL hold its value.
REQ-021 abort_in in IDLE SHALL be ignored.
REQ-022 If abort_in and in_valid_in are both high in IDLE, the accept SHALL proceed.
REQ-023 Abort SHALL have priority over the out_ready_in handshake and over the ROUND->FP transition.
REQ-024 All control outputs except ip_load_out SHALL be decoded from registered state only, with no input-to-output combinational paths.

Reset
REQ-025 rst_n_in low SHALL immediately force state IDLE, round_idx_out=0, key_dir_out=0, key_shift_out=0, round_en_out=0, fp_load_out=0, out_valid_out=0 and busy_out=0, regardless of the clock.
REQ-026 in_ready_out SHALL read 1 while rst_n_in is low; ip_load_out SHALL be forced to 0 while rst_n_in is low.
REQ-027 Reset asserted mid-block SHALL discard the block; no output pulse SHALL follow deassertion.
REQ-028 The first accept SHALL be possible on the first rising edge after rst_n_in deasserts.

Verification
REQ-029 The bench SHALL cover at least these directed scenarios:
- Encrypt block, out_ready_in tied 1, accept at T -> round_en high T+1..T+16; key_shift sequence 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1; fp_load at T+17; out_valid for exactly 1 cycle at T+18.
- Decrypt block -> shift sequence 0,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1; key_dir_out=1 for the whole block; mode_in toggled mid-block has no effect.
- out_ready_in held 0 for 10 cycles in OUT -> out_valid stays 1 and in_ready stays 0; release -> IDLE next cycle; back-to-back second block accepted at T+19.
- abort_in at round 7 -> IDLE next cycle; no fp_load or out_valid; round_idx holds 7; next block runs normally from round 0.
- rst_n_in pulsed low mid-ROUND (asynchronous to clock) -> all outputs at reset values immediately; no spurious pulses after release.
- abort_in and in_valid_in both high in IDLE -> accept occurs; abort raised in the same cycle as the out handshake -> IDLE entered, counted as aborted.

Source files
------------

// File: rtl/des_ctrl.sv
// des_ctrl: round sequencer for an iterative DES core.
// Accepts one 64-bit block and runs the 16 rounds with the matching
// key-schedule rotate amounts. It then pulses the final-permutation capture
// and holds the result valid until downstream takes it. Every control output
// except ip_load_out is decoded from registered state.
module des_ctrl (
  input  logic       clk_in,
  input  logic       rst_n_in,
  input  logic       in_valid_in,
  output logic       in_ready_out,
  input  logic       mode_in,
  input  logic       abort_in,
  output logic       ip_load_out,
  output logic       round_en_out,
  output logic [3:0] round_idx_out,
  output logic [1:0] key_shift_out,
  output logic       key_dir_out,
  output logic       fp_load_out,
  output logic       out_valid_out,
  input  logic       out_ready_in,
  output logic       busy_out
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ROUND = 2'd1;
  localparam logic [1:0] S_FP    = 2'd2;
  localparam logic [1:0] S_OUT   = 2'd3;

  localparam logic [3:0] LAST_ROUND = 4'd15;

  logic [1:0] state;
  logic [3:0] round_idx;
  logic       key_dir;
  logic       accept;

  // Rounds 0, 1, 8 and 15 rotate by one and all others by two. Decrypt skips
  // the rotate in round 0 because it starts from the fully rotated key.
  function automatic logic [1:0] shift_amt(input logic [3:0] idx, input logic dir);
    logic [1:0] amt;
    if (idx == 4'd0 || idx == 4'd1 || idx == 4'd8 || idx == 4'd15)
      amt = (dir && idx == 4'd0) ? 2'd0 : 2'd1;
    else
      amt = 2'd2;
    return amt;
  endfunction

  assign in_ready_out = (state == S_IDLE);
  assign accept       = in_valid_in & in_ready_out;
  // Gated by reset so the IP loader never sees a pulse while the core is held.
  assign ip_load_out  = accept & rst_n_in;

  // Sequencing FSM; abort wins over both the FP transition and the handshake.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state <= S_IDLE;
    end else begin
      case (state)
        S_IDLE:  if (accept) state <= S_ROUND;
        S_ROUND: begin
          if (abort_in)                      state <= S_IDLE;
          else if (round_idx == LAST_ROUND)  state <= S_FP;
        end
        S_FP:    state <= abort_in ? S_IDLE : S_OUT;
        S_OUT:   if (abort_in || out_ready_in) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Round counter and direction latch; the counter parks at 15 and holds on abort.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      round_idx <= 4'd0;
      key_dir   <= 1'b0;
    end else if (accept) begin
      round_idx <= 4'd0;
      key_dir   <= mode_in;
    end else if (state == S_ROUND && !abort_in && round_idx != LAST_ROUND) begin
      round_idx <= round_idx + 4'd1;
    end
  end

  assign round_en_out  = (state == S_ROUND);
  assign round_idx_out = round_idx;
  assign key_dir_out   = key_dir;
  assign key_shift_out = round_en_out ? shift_amt(round_idx, key_dir) : 2'd0;
  assign fp_load_out   = (state == S_FP);
  assign out_valid_out = (state == S_OUT);
  assign busy_out      = (state != S_IDLE);

endmodule

// File: tb/tb_des_ctrl.sv
// Testbench for des_ctrl: directed scenarios followed by randomized traffic,
// compared each cycle against a cycle-count model of the block's timeline.
module tb_des_ctrl;

  logic       clk_in = 1'b0;
  logic       rst_n_in = 1'b0;
  logic       in_valid_in = 1'b0;
  logic       mode_in = 1'b0;
  logic       abort_in = 1'b0;
  logic       out_ready_in = 1'b1;
  logic       in_ready_out;
  logic       ip_load_out;
  logic       round_en_out;
  logic [3:0] round_idx_out;
  logic [1:0] key_shift_out;
  logic       key_dir_out;
  logic       fp_load_out;
  logic       out_valid_out;
  logic       busy_out;

  des_ctrl dut (
    .clk_in        (clk_in),
    .rst_n_in      (rst_n_in),
    .in_valid_in   (in_valid_in),
    .in_ready_out  (in_ready_out),
    .mode_in       (mode_in),
    .abort_in      (abort_in),
    .ip_load_out   (ip_load_out),
    .round_en_out  (round_en_out),
    .round_idx_out (round_idx_out),
    .key_shift_out (key_shift_out),
    .key_dir_out   (key_dir_out),
    .fp_load_out   (fp_load_out),
    .out_valid_out (out_valid_out),
    .out_ready_in  (out_ready_in),
    .busy_out      (busy_out)
  );

  always #5 clk_in = ~clk_in;

  int n_chk = 0;
  int n_err = 0;
  int shift_sum = 0;

  int enc_tab[16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};
  int dec_tab[16] = '{0, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

  // Reference model: a block is a timeline counted in cycles since accept.
  // cnt 1..16 = rounds, 17 = final permutation, 18+ = result waiting.
  bit m_act = 1'b0;
  int m_cnt = 0;
  bit m_dir = 1'b0;
  int m_idx = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_outputs();
    bit e_ren;
    int e_idx;
    int e_shift;
    e_ren   = m_act && (m_cnt <= 16);
    e_idx   = m_act ? ((m_cnt <= 16) ? m_cnt - 1 : 15) : m_idx;
    e_shift = 0;
    if (e_ren) e_shift = m_dir ? dec_tab[m_cnt-1] : enc_tab[m_cnt-1];
    chk("in_ready",  int'(in_ready_out),  int'(!m_act));
    chk("ip_load",   int'(ip_load_out),   int'(in_valid_in && !m_act && rst_n_in));
    chk("round_en",  int'(round_en_out),  int'(e_ren));
    chk("round_idx", int'(round_idx_out), e_idx);
    chk("key_shift", int'(key_shift_out), e_shift);
    chk("key_dir",   int'(key_dir_out),   int'(m_dir));
    chk("fp_load",   int'(fp_load_out),   int'(m_act && m_cnt == 17));
    chk("out_valid", int'(out_valid_out), int'(m_act && m_cnt >= 18));
    chk("busy",      int'(busy_out),      int'(m_act));
    shift_sum += int'(key_shift_out);
  endtask

  task automatic model_step();
    if (!m_act) begin
      if (in_valid_in) begin
        m_act = 1'b1;
        m_cnt = 1;
        m_dir = mode_in;
      end
    end else if (abort_in || (m_cnt >= 18 && out_ready_in)) begin
      m_idx = (m_cnt <= 16) ? m_cnt - 1 : 15;
      m_act = 1'b0;
    end else if (m_cnt < 18) begin
      m_cnt++;
    end
  endtask

  // Called just after a falling edge with inputs already driven.
  task automatic step();
    #1 check_outputs();
    @(posedge clk_in);
    model_step();
    @(negedge clk_in);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_in_ready"},  int'(in_ready_out),  1);
    chk({tag, "_ip_load"},   int'(ip_load_out),   0);
    chk({tag, "_round_en"},  int'(round_en_out),  0);
    chk({tag, "_round_idx"}, int'(round_idx_out), 0);
    chk({tag, "_key_shift"}, int'(key_shift_out), 0);
    chk({tag, "_key_dir"},   int'(key_dir_out),   0);
    chk({tag, "_fp_load"},   int'(fp_load_out),   0);
    chk({tag, "_out_valid"}, int'(out_valid_out), 0);
    chk({tag, "_busy"},      int'(busy_out),      0);
  endtask

  // Asynchronous reset pulse placed between clock edges; returns just after
  // release, before the next rising edge.
  task automatic reset_pulse();
    #3 rst_n_in = 1'b0;
    in_valid_in = 1'b1;
    #1 check_reset_vals("rst_async");
    m_act = 1'b0;
    m_idx = 0;
    m_dir = 1'b0;
    @(posedge clk_in);
    #1 check_reset_vals("rst_held");
    @(negedge clk_in);
    #2 rst_n_in = 1'b1;
    in_valid_in = 1'b0;
    abort_in = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: observed 0 expected 1 (run did not complete)");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n_in = 1'b0;
    repeat (3) @(negedge clk_in);
    check_reset_vals("por");
    rst_n_in = 1'b1;

    // Encrypt block, first accept on the first edge after reset release.
    mode_in = 1'b0; out_ready_in = 1'b1; in_valid_in = 1'b1;
    shift_sum = 0;
    step();
    in_valid_in = 1'b0;
    repeat (19) step();
    chk("enc_shift_sum", shift_sum, 28);

    // Decrypt block with mode toggling mid-flight.
    mode_in = 1'b1; in_valid_in = 1'b1;
    shift_sum = 0;
    step();
    in_valid_in = 1'b0;
    for (int i = 0; i < 19; i++) begin
      mode_in = ~mode_in;
      step();
    end
    chk("dec_shift_sum", shift_sum, 27);

    // Ten-cycle output stall, then release with a second block waiting.
    mode_in = 1'b0; out_ready_in = 1'b0; in_valid_in = 1'b1;
    step();
    in_valid_in = 1'b0;
    repeat (17) step();
    repeat (10) step();
    out_ready_in = 1'b1; in_valid_in = 1'b1;
    step();
    step();
    in_valid_in = 1'b0;
    repeat (19) step();

    // Back-to-back blocks with upstream always valid.
    in_valid_in = 1'b1; out_ready_in = 1'b1;
    repeat (40) step();
    in_valid_in = 1'b0;
    repeat (20) step();

    // Abort at round 7, then a normal block.
    in_valid_in = 1'b1;
    step();
    in_valid_in = 1'b0;
    repeat (7) step();
    abort_in = 1'b1;
    step();
    abort_in = 1'b0;
    step();
    in_valid_in = 1'b1;
    step();
    in_valid_in = 1'b0;
    repeat (19) step();

    // Reset mid-round, then accept right after release.
    in_valid_in = 1'b1;
    step();
    in_valid_in = 1'b0;
    repeat (5) step();
    reset_pulse();
    repeat (3) step();
    in_valid_in = 1'b1;
    step();
    in_valid_in = 1'b0;
    repeat (19) step();

    // Abort with in_valid in IDLE, then abort together with the handshake.
    abort_in = 1'b1; in_valid_in = 1'b1;
    step();
    abort_in = 1'b0; in_valid_in = 1'b0;
    repeat (17) step();
    out_ready_in = 1'b1; abort_in = 1'b1;
    step();
    abort_in = 1'b0;
    repeat (3) step();

    // Randomized traffic with occasional asynchronous resets.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 299) == 0) reset_pulse();
      in_valid_in  = 1'($urandom_range(0, 1));
      mode_in      = 1'($urandom_range(0, 1));
      abort_in     = ($urandom_range(0, 19) == 0);
      out_ready_in = ($urandom_range(0, 2) != 0);
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
